// File: rtl/pll_pkg.sv
// Shared constants and enumerations for the all-digital PLL loop controller.
// Widths here are the defaults; the top level may override them by parameter.
package pll_pkg;

  localparam int CODE_W    = 5;
  localparam int CODE_INIT = 2 ** (CODE_W - 1);
  localparam int STEP_INIT = 2 ** (CODE_W - 2);
  localparam int CODE_MAX  = 2 ** CODE_W - 1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_e;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/code_sat_step.sv
// Saturating add/subtract of a step to the DCO code.
// Purely combinational.
module code_sat_step #(
  parameter int CODE_W = 5
) (
  input  logic [CODE_W-1:0] code,
  input  logic [CODE_W-1:0] step,
  input  logic              up,
  output logic [CODE_W-1:0] code_next
);

  logic [CODE_W:0] sum;
  logic [CODE_W:0] diff;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum  = {1'b0, code} + {1'b0, step};
    diff = {1'b0, code} - {1'b0, step};
    code_next = code;
    if (up) begin
      code_next = sum[CODE_W] ? '1 : sum[CODE_W-1:0];
    end else begin
      code_next = diff[CODE_W] ? '0 : diff[CODE_W-1:0];
    end
  end

endmodule

// File: rtl/pll_controller.sv
// Digital loop controller: binary-search frequency acquisition, then +/-1
// phase tracking. PFD direction is captured on the falling edge of phase_clk.
module pll_controller
  import pll_pkg::*;
#(
  parameter int CODE_W    = pll_pkg::CODE_W,
  parameter int CODE_INIT = 2 ** (CODE_W - 1),
  parameter int STEP_INIT = 2 ** (CODE_W - 2)
) (
  input  logic              phase_clk,
  input  logic              reset,
  input  logic              p_up,
  input  logic              p_down,
  output logic [CODE_W-1:0] dco_code,
  output logic              freq_lock,
  output logic              polarity
);

  localparam logic [CODE_W-1:0] STEP_ONE = CODE_W'(1);

  dir_e              evt;
  lock_state_e       state;
  lock_state_e       state_next;
  logic [CODE_W-1:0] step;
  logic [CODE_W-1:0] step_eff;
  logic [CODE_W-1:0] code_next;
  logic              first_evt;
  logic              is_move;
  logic              move_up;
  logic              reversal;
  logic              lock_set;

  // The PFD pulse is still low at the falling edge, so that is where it is sampled.
  always_ff @(negedge phase_clk) begin
    if (reset) begin
      evt <= NONE;
    end else begin
      unique case ({p_up, p_down})
        2'b01:   evt <= UP;
        2'b10:   evt <= DOWN;
        default: evt <= NONE;
      endcase
    end
  end

  assign is_move  = (evt != NONE);
  assign move_up  = (evt == UP);
  assign reversal = is_move && !first_evt && (move_up != polarity);
  assign lock_set = (state == SEARCH) && reversal && (step == STEP_ONE);

  always_comb begin
    step_eff = step;
    if (state == LOCKED) begin
      step_eff = STEP_ONE;
    end else if (reversal && step != STEP_ONE) begin
      step_eff = step >> 1;
    end
  end

  code_sat_step #(.CODE_W(CODE_W)) u_sat (
    .code      (dco_code),
    .step      (step_eff),
    .up        (move_up),
    .code_next (code_next)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge phase_clk) begin
    if (reset) begin
      dco_code  <= CODE_W'(CODE_INIT);
      step      <= CODE_W'(STEP_INIT);
      polarity  <= 1'b0;
      first_evt <= 1'b1;
    end else if (is_move) begin
      dco_code  <= code_next;
      step      <= step_eff;
      polarity  <= move_up;
      first_evt <= 1'b0;
    end
  end

  always_ff @(posedge phase_clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SEARCH:  if (lock_set) state_next = LOCKED;
      LOCKED:  state_next = LOCKED;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    freq_lock = (state == LOCKED);
  end

endmodule

// File: tb/tb_pll_controller.sv
// Self-checking bench for pll_controller: directed acquisition sequence plus
// randomized PFD pulses compared against an arithmetic reference model.
module tb_pll_controller;

  localparam int CODE_W    = 5;
  localparam int CODE_INIT = 16;
  localparam int STEP_INIT = 8;
  localparam int CODE_MAX  = 31;

  // stimulus kinds
  localparam int K_NONE = 0;
  localparam int K_UP   = 1;
  localparam int K_DOWN = 2;
  localparam int K_BOTH = 3;

  logic              phase_clk = 1'b0;
  logic              reset     = 1'b1;
  logic              p_up      = 1'b1;
  logic              p_down    = 1'b1;
  logic [CODE_W-1:0] dco_code;
  logic              freq_lock;
  logic              polarity;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_code;
  int m_step;
  int m_pol;
  int m_first;
  int m_lock;

  pll_controller #(
    .CODE_W    (CODE_W),
    .CODE_INIT (CODE_INIT),
    .STEP_INIT (STEP_INIT)
  ) dut (
    .phase_clk (phase_clk),
    .reset     (reset),
    .p_up      (p_up),
    .p_down    (p_down),
    .dco_code  (dco_code),
    .freq_lock (freq_lock),
    .polarity  (polarity)
  );

  always #5 phase_clk = ~phase_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_code  = CODE_INIT;
    m_step  = STEP_INIT;
    m_pol   = 0;
    m_first = 1;
    m_lock  = 0;
  endtask

  // Binary search: halve on reversal, lock on a reversal at step 1, then +/-1.
  task automatic model_event(input int kind);
    int dir_up;
    int amount;
    if (kind != K_UP && kind != K_DOWN) return;
    dir_up = (kind == K_UP) ? 1 : 0;
    if (!m_first && !m_lock && dir_up != m_pol) begin
      if (m_step == 1) m_lock = 1;
      else             m_step = m_step / 2;
    end
    m_first = 0;
    amount  = m_lock ? 1 : m_step;
    m_code  = dir_up ? m_code + amount : m_code - amount;
    if (m_code > CODE_MAX) m_code = CODE_MAX;
    if (m_code < 0)        m_code = 0;
    m_pol = dir_up;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".code"}, int'(dco_code), m_code);
    check({tag, ".lock"}, int'(freq_lock), m_lock);
    check({tag, ".pol"},  int'(polarity), m_pol);
  endtask

  // One PFD comparison: pulse spans the falling edge, released before the rising edge.
  task automatic pulse(input int kind);
    p_up   = (kind == K_UP   || kind == K_BOTH) ? 1'b0 : 1'b1;
    p_down = (kind == K_DOWN || kind == K_BOTH) ? 1'b0 : 1'b1;
    @(negedge phase_clk);
    #1;
    p_up   = 1'b1;
    p_down = 1'b1;
    @(posedge phase_clk);
    #1;
    model_event(kind);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge phase_clk);
    @(posedge phase_clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // directed acquisition sequence with hand-derived expected codes/lock
  int d_kind [17] = '{K_UP, K_UP, K_UP, K_DOWN, K_DOWN, K_DOWN, K_DOWN, K_UP, K_UP,
                      K_DOWN, K_UP, K_DOWN, K_UP, K_DOWN, K_UP, K_BOTH, K_NONE};
  int d_code [17] = '{24, 31, 31, 27, 23, 19, 15, 17, 19, 18, 19, 18, 19, 18, 19, 19, 19};
  int d_lock [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    int kind;
    model_reset();
    do_reset();
    check("reset.code", int'(dco_code), 16);
    check("reset.lock", int'(freq_lock), 0);
    check("reset.pol",  int'(polarity), 0);

    for (int i = 0; i < 17; i++) begin
      pulse(d_kind[i]);
      check($sformatf("dir%0d.code", i), int'(dco_code), d_code[i]);
      check($sformatf("dir%0d.lock", i), int'(freq_lock), d_lock[i]);
      check($sformatf("dir%0d.pol", i),  int'(polarity), m_pol);
    end

    // reset after lock
    do_reset();
    check("rst_lock.code", int'(dco_code), 16);
    check("rst_lock.lock", int'(freq_lock), 0);
    check("rst_lock.pol",  int'(polarity), 0);

    // pending UP captured at the falling edge, then reset at the rising edge: discarded
    pulse(K_UP);
    check_model("pre_discard");
    p_up = 1'b0;
    @(negedge phase_clk);
    #1;
    p_up  = 1'b1;
    reset = 1'b1;
    @(posedge phase_clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_model("discard");
    pulse(K_NONE);
    check_model("discard_idle");
    pulse(K_DOWN);
    check_model("discard_first");

    // randomized pulses against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        check_model($sformatf("rnd_rst%0d", n));
      end
      kind = int'($urandom_range(0, 9));
      kind = (kind < 4) ? K_UP : (kind < 8) ? K_DOWN : (kind == 8) ? K_BOTH : K_NONE;
      pulse(kind);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
